// File: rtl/reset_seq_pkg.sv
// ----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and helpers for the board reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   rst_cause_e     : encoding of what started the most recent sequence
//   CauseW          : width of the cause field on the sequencer interface
//   max3/clog2_min1 : elaboration-time sizing helpers for counters
// ----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLDOFF = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_e;

    localparam int unsigned CauseW = 2;

    typedef enum logic [CauseW-1:0] {
        CausePor = 2'd0,
        CausePll = 2'd1,
        CauseExt = 2'd2,
        CauseSw  = 2'd3
    } rst_cause_e;

    // Largest of three cycle counts; the shared counter must reach all of them.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the reset-request inputs and the staged reset outputs of the
// sequencer so the board top can pass them around as one bundle.
//   pll_locked_i  : async PLL lock indication
//   ext_rst_req_i : async board reset button, active-high level
//   sw_rst_req_i  : synchronous single-cycle reset request (debug/software)
//   rst_domain_no : active-low domain resets, bit 0 releases first
//   seq_done_o    : high while every domain is released
//   rst_cause_o   : cause of the last sequence (see rst_cause_e)
// Modports: master = the sequencer, slave = the board logic around it.
// ----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int unsigned NumDomains = 3
);
    import reset_seq_pkg::*;

    logic                  pll_locked_i;
    logic                  ext_rst_req_i;
    logic                  sw_rst_req_i;
    logic [NumDomains-1:0] rst_domain_no;
    logic                  seq_done_o;
    logic [CauseW-1:0]     rst_cause_o;

    modport master (
        input  pll_locked_i,
        input  ext_rst_req_i,
        input  sw_rst_req_i,
        output rst_domain_no,
        output seq_done_o,
        output rst_cause_o
    );

    modport slave (
        output pll_locked_i,
        output ext_rst_req_i,
        output sw_rst_req_i,
        input  rst_domain_no,
        input  seq_done_o,
        input  rst_cause_o
    );

endinterface

// File: rtl/reset_seq_sync.sv
// ----------------------------------------------------------------------------
// reset_seq_sync
// Plain flop-chain synchroniser for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears the chain to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output, SyncStages clocks behind d_i
// ----------------------------------------------------------------------------
module reset_seq_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] sync_q;
    logic [SyncStages-1:0] sync_d;

    // Shift the raw input into the bottom of the chain each clock.
    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], d_i};
    end

    // Chain registers; cleared so a just-reset system reads "unlocked/idle".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
// Board reset sequencer: waits for a stable PLL lock, holds every domain in
// reset for a programmed window, then releases the domains one at a time
// (interconnect first, core last). PLL loss, the board button or a software
// pulse restart the sequence and the cause is recorded.
//   clk_sys_i : system clock
//   rst_sys_i : synchronous active-high reset of the sequencer itself
//   bus       : reset_sequencer_if.master (requests in, domain resets out)
// ----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NumDomains     = 3,
    parameter int unsigned HoldoffCycles  = 5,
    parameter int unsigned AssertCycles   = 195,
    parameter int unsigned StageGapCycles = 16,
    parameter int unsigned SyncStages     = 2
) (
    input  logic               clk_sys_i,
    input  logic               rst_sys_i,
    reset_sequencer_if.master  bus
);

    localparam int unsigned MaxCycles = max3(HoldoffCycles, AssertCycles, StageGapCycles);
    localparam int unsigned CntW      = clog2_min1(MaxCycles);
    localparam int unsigned StW       = clog2_min1(NumDomains);

    localparam logic [CntW-1:0] HoldLast   = CntW'(HoldoffCycles - 1);
    localparam logic [CntW-1:0] AssertLast = CntW'(AssertCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(StageGapCycles - 1);
    localparam logic [StW-1:0]  LastStage  = StW'(NumDomains - 1);

    // Reject parameter sets the counters and the release order cannot handle.
    if (NumDomains == 0) begin : g_chk_domains
        $fatal(1, "reset_sequencer: NumDomains must be >= 1");
    end
    if (HoldoffCycles == 0) begin : g_chk_holdoff
        $fatal(1, "reset_sequencer: HoldoffCycles must be >= 1");
    end
    if (AssertCycles == 0) begin : g_chk_assert
        $fatal(1, "reset_sequencer: AssertCycles must be >= 1");
    end
    if (StageGapCycles == 0) begin : g_chk_gap
        $fatal(1, "reset_sequencer: StageGapCycles must be >= 1");
    end
    if (SyncStages < 2) begin : g_chk_sync
        $fatal(1, "reset_sequencer: SyncStages must be >= 2");
    end

    logic lock_sync;
    logic ext_sync;

    reset_seq_sync #(.SyncStages(SyncStages)) u_sync_lock (
        .clk_i (clk_sys_i),
        .rst_i (rst_sys_i),
        .d_i   (bus.pll_locked_i),
        .q_o   (lock_sync)
    );

    reset_seq_sync #(.SyncStages(SyncStages)) u_sync_ext (
        .clk_i (clk_sys_i),
        .rst_i (rst_sys_i),
        .d_i   (bus.ext_rst_req_i),
        .q_o   (ext_sync)
    );

    rst_seq_state_e        state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [StW-1:0]        stage_q, stage_d;
    logic [StW-1:0]        stage_inc;
    logic [NumDomains-1:0] rst_domain_q, rst_domain_d;
    logic                  seq_done_q, seq_done_d;
    rst_cause_e            cause_q, cause_d;
    // Set once any sequence has reached RUN since rst_sys_i; decides whether
    // a lock loss during HOLDOFF counts as a PLL event or is still power-on.
    logic                  seq_seen_q, seq_seen_d;

    assign stage_inc = stage_q + StW'(1);

    // Next-state logic. Re-entry requests are checked first in every state,
    // PLL loss over button over software. Without a request the FSM steps
    // through holdoff -> assert window -> staged release -> run. Released
    // domains form a thermometer code, so each release shifts in another 1.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        rst_domain_d = rst_domain_q;
        seq_done_d   = seq_done_q;
        cause_d      = cause_q;
        seq_seen_d   = seq_seen_q;

        if (!lock_sync) begin
            state_d      = HOLDOFF;
            cnt_d        = '0;
            stage_d      = '0;
            rst_domain_d = '0;
            seq_done_d   = 1'b0;
            if (state_q != HOLDOFF || seq_seen_q) begin
                cause_d = CausePll;
            end
        end else if (ext_sync) begin
            state_d      = ASSERT;
            cnt_d        = '0;
            stage_d      = '0;
            rst_domain_d = '0;
            seq_done_d   = 1'b0;
            cause_d      = CauseExt;
        end else if (bus.sw_rst_req_i) begin
            state_d      = ASSERT;
            cnt_d        = '0;
            stage_d      = '0;
            rst_domain_d = '0;
            seq_done_d   = 1'b0;
            cause_d      = CauseSw;
        end else begin
            case (state_q)
                HOLDOFF: begin
                    if (cnt_q == HoldLast) begin
                        state_d = ASSERT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ASSERT: begin
                    if (cnt_q == AssertLast) begin
                        cnt_d        = '0;
                        stage_d      = '0;
                        rst_domain_d = NumDomains'(1);
                        if (NumDomains == 1) begin
                            state_d    = RUN;
                            seq_done_d = 1'b1;
                            seq_seen_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == GapLast) begin
                        cnt_d        = '0;
                        stage_d      = stage_inc;
                        rst_domain_d = NumDomains'({rst_domain_q, 1'b1});
                        if (stage_inc == LastStage) begin
                            state_d    = RUN;
                            seq_done_d = 1'b1;
                            seq_seen_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                RUN: begin
                    seq_done_d = 1'b1;
                end
                default: begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q      <= HOLDOFF;
            cnt_q        <= '0;
            stage_q      <= '0;
            rst_domain_q <= '0;
            seq_done_q   <= 1'b0;
            cause_q      <= CausePor;
            seq_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            rst_domain_q <= rst_domain_d;
            seq_done_q   <= seq_done_d;
            cause_q      <= cause_d;
            seq_seen_q   <= seq_seen_d;
        end
    end

    assign bus.rst_domain_no = rst_domain_q;
    assign bus.seq_done_o    = seq_done_q;
    assign bus.rst_cause_o   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer. A default-parameter instance walks
// through power-on, late lock, software, button and PLL-loss sequences; a
// minimal-parameter instance (one domain, all windows of one cycle) shares
// clock and reset. Expected outputs are queued with the cycle at which they
// must appear and compared as the simulation reaches that cycle.
// Cycle numbering: edge 1 is the first rising edge that samples rst low;
// "cycle n" values are the outputs visible just after edge n.
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NumDomains(3)) bus0 ();
    reset_sequencer_if #(.NumDomains(1)) bus1 ();

    reset_sequencer #(
        .NumDomains     (3),
        .HoldoffCycles  (5),
        .AssertCycles   (195),
        .StageGapCycles (16),
        .SyncStages     (2)
    ) u_dut (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .bus       (bus0.master)
    );

    reset_sequencer #(
        .NumDomains     (1),
        .HoldoffCycles  (1),
        .AssertCycles   (1),
        .StageGapCycles (1),
        .SyncStages     (2)
    ) u_dut_min (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .bus       (bus1.master)
    );

    typedef struct {
        int         cycle;
        int         dut;
        logic [5:0] value;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   assert_count;
    int   fail_count;

    // Packs {domains, done, cause} of one instance; the one-domain instance
    // is zero-extended to the same 6-bit layout.
    function automatic logic [5:0] observe(input int dut);
        if (dut == 0) begin
            return {bus0.rst_domain_no, bus0.seq_done_o, bus0.rst_cause_o};
        end
        return {2'b00, bus1.rst_domain_no, bus1.seq_done_o, bus1.rst_cause_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] observed,
                               input logic [5:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int cycle, input int dut, input logic [2:0] dom,
                           input logic done, input logic [1:0] cause, input string name);
        exp_t e;
        e.cycle = cycle;
        e.dut   = dut;
        e.value = {dom, done, cause};
        e.tag   = $sformatf("%s@%0d", name, cycle);
        sb.push_back(e);
    endtask

    // One clock: advance, sample 1 time unit after the edge, retire due entries.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].cycle <= cyc) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.dut), e.value);
        end
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    // Drives the default instance's request inputs on the falling edge.
    task automatic applyStimulus(input logic lock, input logic ext, input logic sw);
        @(negedge clk);
        bus0.pll_locked_i  = lock;
        bus0.ext_rst_req_i = ext;
        bus0.sw_rst_req_i  = sw;
    endtask

    task automatic doReset(input logic lock);
        @(negedge clk);
        rst                = 1'b1;
        bus0.pll_locked_i  = lock;
        bus0.ext_rst_req_i = 1'b0;
        bus0.sw_rst_req_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state_dut", observe(0), 6'b000_0_00);
        checkOutput("reset_state_min", observe(1), 6'b000_0_00);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        assert_count       = 0;
        fail_count         = 0;
        cyc                = 0;
        rst                = 1'b1;
        bus0.pll_locked_i  = 1'b1;
        bus0.ext_rst_req_i = 1'b0;
        bus0.sw_rst_req_i  = 1'b0;
        bus1.pll_locked_i  = 1'b1;
        bus1.ext_rst_req_i = 1'b0;
        bus1.sw_rst_req_i  = 1'b0;

        $display("[TB] power-on sequence, lock stable");
        doReset(1'b1);
        pushExp(1,   0, 3'b000, 1'b0, 2'd0, "por_early");
        pushExp(3,   1, 3'b000, 1'b0, 2'd0, "min_before");
        pushExp(4,   1, 3'b001, 1'b1, 2'd0, "min_release");
        pushExp(201, 0, 3'b000, 1'b0, 2'd0, "por_pre_d0");
        pushExp(202, 0, 3'b001, 1'b0, 2'd0, "por_d0");
        pushExp(217, 0, 3'b001, 1'b0, 2'd0, "por_pre_d1");
        pushExp(218, 0, 3'b011, 1'b0, 2'd0, "por_d1");
        pushExp(233, 0, 3'b011, 1'b0, 2'd0, "por_pre_d2");
        pushExp(234, 0, 3'b111, 1'b1, 2'd0, "por_d2_done");
        runTo(240);

        $display("[TB] power-on with lock arriving 50 cycles late");
        doReset(1'b0);
        pushExp(30,  0, 3'b000, 1'b0, 2'd0, "late_wait");
        pushExp(251, 0, 3'b000, 1'b0, 2'd0, "late_pre_d0");
        pushExp(252, 0, 3'b001, 1'b0, 2'd0, "late_d0");
        pushExp(267, 0, 3'b001, 1'b0, 2'd0, "late_pre_d1");
        pushExp(268, 0, 3'b011, 1'b0, 2'd0, "late_d1");
        pushExp(283, 0, 3'b011, 1'b0, 2'd0, "late_pre_d2");
        pushExp(284, 0, 3'b111, 1'b1, 2'd0, "late_d2_done");
        runTo(50);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTo(289);

        $display("[TB] software reset pulse in RUN");
        pushExp(290, 0, 3'b111, 1'b1, 2'd0, "sw_before");
        pushExp(291, 0, 3'b000, 1'b0, 2'd3, "sw_assert");
        pushExp(485, 0, 3'b000, 1'b0, 2'd3, "sw_pre_d0");
        pushExp(486, 0, 3'b001, 1'b0, 2'd3, "sw_d0");
        pushExp(502, 0, 3'b011, 1'b0, 2'd3, "sw_d1");
        pushExp(517, 0, 3'b011, 1'b0, 2'd3, "sw_pre_d2");
        pushExp(518, 0, 3'b111, 1'b1, 2'd3, "sw_done");
        runTo(290);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runTo(291);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTo(529);

        $display("[TB] board button held for 300 cycles in RUN");
        pushExp(532,  0, 3'b111, 1'b1, 2'd3, "ext_before");
        pushExp(533,  0, 3'b000, 1'b0, 2'd2, "ext_assert");
        pushExp(700,  0, 3'b000, 1'b0, 2'd2, "ext_held");
        pushExp(1026, 0, 3'b000, 1'b0, 2'd2, "ext_pre_d0");
        pushExp(1027, 0, 3'b001, 1'b0, 2'd2, "ext_d0");
        pushExp(1043, 0, 3'b011, 1'b0, 2'd2, "ext_d1");
        pushExp(1059, 0, 3'b111, 1'b1, 2'd2, "ext_done");
        runTo(530);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runTo(830);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTo(1069);

        $display("[TB] software request and lock loss together");
        pushExp(1070, 0, 3'b111, 1'b1, 2'd2, "pll_before");
        pushExp(1071, 0, 3'b000, 1'b0, 2'd3, "pll_sw_first");
        pushExp(1072, 0, 3'b000, 1'b0, 2'd3, "pll_sw_hold");
        pushExp(1073, 0, 3'b000, 1'b0, 2'd1, "pll_holdoff");
        pushExp(1301, 0, 3'b000, 1'b0, 2'd1, "pll_pre_d0");
        pushExp(1302, 0, 3'b001, 1'b0, 2'd1, "pll_d0");
        pushExp(1334, 0, 3'b111, 1'b1, 2'd1, "pll_done");
        runTo(1070);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runTo(1071);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runTo(1100);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTo(1340);

        checkOutput("scoreboard_drained", 6'(sb.size()), 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
